// File: rtl/rca8_multibyte_seq.sv
// ---------------------------------------------------------------------------
// rca8_multibyte_seq
//   Sequencer that drives an external 8-bit ripple-carry adder to perform a
//   wide (8*NBYTES-bit) addition one byte per clock, LSB byte first. Each
//   byte's carry-out is registered and fed back as the next byte's carry-in.
//
//   Optional feature macro: RCA8_SEQ_OVF_EN
//     defined   -> signed overflow flag computed on the final byte
//     undefined -> ovf tied to 0, no overflow logic
//
// Ports
//   clk       in   1  system clock, rising edge
//   rst_n     in   1  synchronous active-low reset
//   start     in   1  latch a_in/b_in/cin and begin an addition
//   a_in      in   W  operand A
//   b_in      in   W  operand B
//   cin       in   1  carry-in to byte 0
//   rca_a     out  8  byte of A presented to the adder
//   rca_b     out  8  byte of B presented to the adder
//   rca_cin   out  1  carry presented to the adder
//   rca_s     in   8  adder sum (combinational from rca_a/rca_b/rca_cin)
//   rca_cout  in   1  adder carry-out
//   busy      out  1  high while bytes are being added
//   done      out  1  one-cycle pulse, result valid
//   sum_out   out  W  result, held until the next accepted start
//   cout      out  1  final carry-out, held with sum_out
//   ovf       out  1  signed overflow (0 unless RCA8_SEQ_OVF_EN)
// ---------------------------------------------------------------------------
module rca8_multibyte_seq #(
   parameter  int NBYTES = 4,
   localparam int W      = 8 * NBYTES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a_in,
   input  logic [W-1:0] b_in,
   input  logic         cin,
   output logic [7:0]   rca_a,
   output logic [7:0]   rca_b,
   output logic         rca_cin,
   input  logic [7:0]   rca_s,
   input  logic         rca_cout,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum_out,
   output logic         cout,
   output logic         ovf
);

   // Index is kept at least one bit wide so NBYTES=1 still elaborates.
   localparam int            IW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q;
   logic [W-1:0]  a_lat, b_lat, sum_q;
   logic          cin_lat, carry_q, cout_q;
   logic          accept, last;

   // A start is honoured in IDLE and DONE (back-to-back), never mid-RUN.
   assign accept = start && (state_q != RUN);
   assign last   = (idx_q == LAST);

   always_comb begin
      state_d = state_q;
      rca_a   = 8'h00;
      rca_b   = 8'h00;
      rca_cin = 1'b0;
      unique case (state_q)
         IDLE: if (start) state_d = RUN;
         RUN: begin
            rca_a   = a_lat[8*idx_q +: 8];
            rca_b   = b_lat[8*idx_q +: 8];
            // Byte 0 takes the caller's carry; later bytes the ripple carry.
            rca_cin = (idx_q == '0) ? cin_lat : carry_q;
            if (last) state_d = DONE;
         end
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_lat   <= '0;
         b_lat   <= '0;
         cin_lat <= 1'b0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            a_lat   <= a_in;
            b_lat   <= b_in;
            cin_lat <= cin;
            idx_q   <= '0;
         end else if (state_q == RUN) begin
            sum_q[8*idx_q +: 8] <= rca_s;
            carry_q             <= rca_cout;
            if (last) begin
               idx_q  <= '0;
               cout_q <= rca_cout;
            end else begin
               idx_q  <= idx_q + 1'b1;
            end
         end
      end
   end

`ifdef RCA8_SEQ_OVF_EN
   // Carry into the MSB is recovered from the sum bit: s7 = a7^b7^c_in7.
   logic ovf_q;
   always_ff @(posedge clk) begin
      if (!rst_n)
         ovf_q <= 1'b0;
      else if (accept)
         ovf_q <= 1'b0;
      else if (state_q == RUN && last)
         ovf_q <= rca_cout ^ (rca_a[7] ^ rca_b[7] ^ rca_s[7]);
   end
   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   assign busy    = (state_q == RUN);
   assign done    = (state_q == DONE);
   assign sum_out = sum_q;
   assign cout    = cout_q;

endmodule

// File: tb/tb_rca8_multibyte_seq.sv
// ---------------------------------------------------------------------------
// tb_rca8_multibyte_seq
//   Directed bench for rca8_multibyte_seq (NBYTES=4) with an ideal 8-bit
//   adder closing the rca_* loop. Expected results are queued when an
//   operation is issued; a monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_rca8_multibyte_seq;

   localparam int NB = 4;
   localparam int W  = 8 * NB;

   logic         clk = 1'b0;
   logic         rst_n, start, cin;
   logic [W-1:0] a_in, b_in;
   logic [7:0]   rca_a, rca_b, rca_s;
   logic         rca_cin, rca_cout;
   logic         busy, done, cout, ovf;
   logic [W-1:0] sum_out;

   rca8_multibyte_seq #(.NBYTES(NB)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
      .cin(cin), .rca_a(rca_a), .rca_b(rca_b), .rca_cin(rca_cin),
      .rca_s(rca_s), .rca_cout(rca_cout), .busy(busy), .done(done),
      .sum_out(sum_out), .cout(cout), .ovf(ovf)
   );

   // Ideal adder
   assign {rca_cout, rca_s} = {1'b0, rca_a} + {1'b0, rca_b} + {8'h00, rca_cin};

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] sum;
      logic         co;
      logic         ov;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   done_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compare every done pulse against the oldest queued result.
   always @(negedge clk) begin
      if (rst_n && done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sum_out", 64'(sum_out), 64'(e.sum));
            chk("cout",    64'(cout),    64'(e.co));
            chk("ovf",     64'(ovf),     64'(e.ov));
         end
      end
   end

   // Issue a start at the current negedge; returns one cycle later with
   // operand inputs scrambled so late changes would corrupt a wrong design.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] s, input logic co, input logic ov_en);
      exp_t e;
      e.sum = s;
      e.co  = co;
`ifdef RCA8_SEQ_OVF_EN
      e.ov  = ov_en;
`else
      e.ov  = 1'b0;
`endif
      exp_q.push_back(e);
      start = 1'b1; a_in = a; b_in = b; cin = c;
      @(negedge clk);
      start = 1'b0; a_in = 32'hDEAD_BEEF; b_in = 32'h1357_9BDF; cin = ~c;
   endtask

   // Called in the first cycle after the accepting edge: expects NB busy
   // cycles then a done cycle; returns at the negedge of the done cycle.
   task automatic check_timing(input string tag);
      for (int i = 0; i < NB; i++) begin
         chk({tag, "_busy"},  64'(busy), 64'd1);
         chk({tag, "_nodone"}, 64'(done), 64'd0);
         @(negedge clk);
      end
      chk({tag, "_done"},     64'(done), 64'd1);
      chk({tag, "_busy_off"}, 64'(busy), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc;
      rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy",  64'(busy),    64'd0);
      chk("rst_done",  64'(done),    64'd0);
      chk("rst_sum",   64'(sum_out), 64'd0);
      chk("rst_cout",  64'(cout),    64'd0);
      chk("rst_ovf",   64'(ovf),     64'd0);
      chk("rst_rca_a", 64'(rca_a),   64'd0);
      chk("rst_rcacin",64'(rca_cin), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: carry from byte 0 into byte 1
      issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
      check_timing("t1");
      @(negedge clk);
      @(negedge clk);
      chk("t1_hold_sum", 64'(sum_out), 64'h100);
      chk("idle_rca_b",  64'(rca_b),   64'd0);

      // 2: full ripple across all bytes
      issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
      check_timing("t2");
      @(negedge clk);

      // 3: signed overflow
      issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      check_timing("t3");
      @(negedge clk);

      // 4: start during RUN is ignored
      dc = done_cnt;
      issue(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
      start = 1'b1; a_in = 32'h0F0F_0F0F; b_in = 32'h0101_0101; cin = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      chk("t4_one_done", 64'(done_cnt - dc), 64'd1);

      // 5: reset mid-RUN aborts with no done
      issue(32'h0101_0101, 32'h0101_0101, 1'b0, 32'h0202_0202, 1'b0, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      dc = done_cnt;
      chk("t5_busy", 64'(busy),    64'd0);
      chk("t5_done", 64'(done),    64'd0);
      chk("t5_sum",  64'(sum_out), 64'd0);
      chk("t5_cout", 64'(cout),    64'd0);
      repeat (6) @(negedge clk);
      chk("t5_no_done", 64'(done_cnt - dc), 64'd0);
      issue(32'h0000_FFFF, 32'h0000_0001, 1'b1, 32'h0001_0001, 1'b0, 1'b0);
      check_timing("t5b");
      @(negedge clk);

      // 6: back-to-back start in the DONE cycle
      issue(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      check_timing("t6a");
      issue(32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
      check_timing("t6b");
      @(negedge clk);
      @(negedge clk);

      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
